// File: rtl/synth_pkg.sv
// Shared synth definitions: envelope state encoding and full-scale envelope level.
package synth_pkg;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_env_if.sv
// Voice-side bundle of the ADSR envelope: sample strobe, gate, rates, and enveloped output.
interface adsr_env_if #(
  parameter int WIDTH     = 18,
  parameter int ENV_BITS  = 16,
  parameter int RATE_BITS = 16
);
  logic                        sample_en;
  logic                        gate;
  logic signed [WIDTH-1:0]     wave_in;
  logic        [RATE_BITS-1:0] attack_rate;
  logic        [RATE_BITS-1:0] decay_rate;
  logic        [RATE_BITS-1:0] release_rate;
  logic        [ENV_BITS-1:0]  sustain_lvl;
  logic signed [WIDTH-1:0]     wave_out;
  logic                        wave_valid;
  logic        [ENV_BITS-1:0]  env_level;
  logic                        active;

  modport master (
    output sample_en, gate, wave_in, attack_rate, decay_rate, release_rate, sustain_lvl,
    input  wave_out, wave_valid, env_level, active
  );

  modport slave (
    input  sample_en, gate, wave_in, attack_rate, decay_rate, release_rate, sustain_lvl,
    output wave_out, wave_valid, env_level, active
  );
endinterface

// File: rtl/env_mult.sv
// Two-stage signed sample x unsigned level multiplier with floor shift; valid travels with data.
module env_mult #(
  parameter int WIDTH    = 18,
  parameter int ENV_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    sample,
  input  logic        [ENV_BITS-1:0] level,
  output logic                       out_valid,
  output logic signed [WIDTH-1:0]    out_sample
);
  localparam int PW = WIDTH + ENV_BITS + 1;

  logic signed [PW-1:0]    a_s;
  logic signed [PW-1:0]    b_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [PW-1:0]    prod_r;
  logic                    v1_r;
  logic                    v2_r;
  logic signed [WIDTH-1:0] out_r;
  logic                    unused_bits_s;

  assign a_s    = PW'(sample);
  assign b_s    = PW'($signed({1'b0, level}));
  assign prod_s = a_s * b_s;

  // Stage 1: register the full product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= {PW{1'b0}};
      v1_r   <= 1'b0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        prod_r <= prod_s;
      end
    end
  end

  // Stage 2: dropping the low ENV_BITS bits of a two's complement value floors toward -inf
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
      v2_r  <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        out_r <= prod_r[PW-2:ENV_BITS];
      end
    end
  end

  assign unused_bits_s = ^{prod_r[PW-1], prod_r[ENV_BITS-1:0]};
  assign out_valid     = v2_r;
  assign out_sample    = out_r;
endmodule

// File: rtl/adsr_env.sv
// Single-voice ADSR envelope generator with amplitude scaler.
// Optional EXP_DECAY_EN: exponential decay/release steps; default build is linear.
module adsr_env
  import synth_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int ENV_BITS  = 16,
  parameter int RATE_BITS = 16
) (
  input logic      clk,
  input logic      rst,
  adsr_env_if.slave bus
);
  localparam int                 EW      = ENV_BITS + 1;
  localparam logic [ENV_BITS-1:0] LVL_MAX  = {ENV_BITS{1'b1}};
  localparam logic [ENV_BITS-1:0] LVL_ZERO = {ENV_BITS{1'b0}};
  localparam logic [EW-1:0]       ONE_E    = {{ENV_BITS{1'b0}}, 1'b1};

  logic [2:0]          state_r;
  logic [2:0]          state_nxt;
  logic [ENV_BITS-1:0] lvl_r;
  logic [ENV_BITS-1:0] lvl_nxt;
  logic                active_r;

  logic [EW-1:0] sum_s;
  logic [EW-1:0] dec_step_s;
  logic [EW-1:0] rel_step_s;
  logic [EW-1:0] dec_diff_s;
  logic [EW-1:0] rel_diff_s;
  logic          dec_instant_s;
  logic          rel_instant_s;
  logic          atk_sat_s;
  logic          dec_done_s;
  logic          rel_done_s;

`ifdef EXP_DECAY_EN
  logic [ENV_BITS-1:0] dec_excess_s;
  logic                unused_rate_s;

  assign dec_excess_s  = (lvl_r > bus.sustain_lvl) ? (lvl_r - bus.sustain_lvl) : LVL_ZERO;
  assign dec_step_s    = ({1'b0, dec_excess_s} >> bus.decay_rate[3:0]) + ONE_E;
  assign rel_step_s    = ({1'b0, lvl_r} >> bus.release_rate[3:0]) + ONE_E;
  assign dec_instant_s = 1'b0;
  assign rel_instant_s = 1'b0;
  assign unused_rate_s = ^{bus.decay_rate[RATE_BITS-1:4], bus.release_rate[RATE_BITS-1:4]};
`else
  assign dec_step_s    = EW'(bus.decay_rate);
  assign rel_step_s    = EW'(bus.release_rate);
  assign dec_instant_s = (bus.decay_rate == {RATE_BITS{1'b0}});
  assign rel_instant_s = (bus.release_rate == {RATE_BITS{1'b0}});
`endif

  // One extra bit catches both overflow on attack and borrow on decay/release
  assign sum_s      = {1'b0, lvl_r} + EW'(bus.attack_rate);
  assign dec_diff_s = {1'b0, lvl_r} - dec_step_s;
  assign rel_diff_s = {1'b0, lvl_r} - rel_step_s;

  assign atk_sat_s  = (bus.attack_rate == {RATE_BITS{1'b0}}) || (sum_s >= {1'b0, LVL_MAX});
  assign dec_done_s = dec_instant_s || dec_diff_s[EW-1] ||
                      (dec_diff_s[ENV_BITS-1:0] <= bus.sustain_lvl);
  assign rel_done_s = rel_instant_s || rel_diff_s[EW-1] ||
                      (rel_diff_s[ENV_BITS-1:0] == LVL_ZERO);

  // Next-state and next-level; gate changes win over level-driven transitions
  always_comb begin
    state_nxt = state_r;
    lvl_nxt   = lvl_r;
    if (bus.sample_en) begin
      case (state_r)
        ST_IDLE: begin
          lvl_nxt   = LVL_ZERO;
          state_nxt = bus.gate ? ST_ATTACK : ST_IDLE;
        end
        ST_ATTACK: begin
          if (!bus.gate) begin
            state_nxt = ST_RELEASE;
          end else if (atk_sat_s) begin
            lvl_nxt   = LVL_MAX;
            state_nxt = ST_DECAY;
          end else begin
            lvl_nxt = sum_s[ENV_BITS-1:0];
          end
        end
        ST_DECAY: begin
          if (!bus.gate) begin
            state_nxt = ST_RELEASE;
          end else if (dec_done_s) begin
            lvl_nxt   = bus.sustain_lvl;
            state_nxt = ST_SUSTAIN;
          end else begin
            lvl_nxt = dec_diff_s[ENV_BITS-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!bus.gate) begin
            state_nxt = ST_RELEASE;
          end else begin
            lvl_nxt = bus.sustain_lvl;
          end
        end
        ST_RELEASE: begin
          if (bus.gate) begin
            state_nxt = ST_ATTACK;
          end else if (rel_done_s) begin
            lvl_nxt   = LVL_ZERO;
            state_nxt = ST_IDLE;
          end else begin
            lvl_nxt = rel_diff_s[ENV_BITS-1:0];
          end
        end
        default: begin
          lvl_nxt   = LVL_ZERO;
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
      lvl_nxt   = lvl_r;
    end
  end

  // Envelope state, level and activity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      lvl_r    <= LVL_ZERO;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      lvl_r    <= lvl_nxt;
      active_r <= (state_nxt != ST_IDLE);
    end
  end

  // The scaler sees the level registered before this tick's update
  env_mult #(
    .WIDTH   (WIDTH),
    .ENV_BITS(ENV_BITS)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.sample_en),
    .sample    (bus.wave_in),
    .level     (lvl_r),
    .out_valid (bus.wave_valid),
    .out_sample(bus.wave_out)
  );

  assign bus.env_level = lvl_r;
  assign bus.active    = active_r;
endmodule

// File: tb/tb_adsr_env.sv
// Scoreboard bench for adsr_env: directed ticks, level/active checked per tick, waves checked by a monitor.
module tb_adsr_env;
  import synth_pkg::*;

  localparam int NOHAND = 32'h7FFF_FFFF;

  typedef struct {
    int                 due;
    logic signed [17:0] wave;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [15:0] mdl_lvl = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adsr_env_if #(.WIDTH(18), .ENV_BITS(16), .RATE_BITS(16)) bus ();

  adsr_env #(.WIDTH(18), .ENV_BITS(16), .RATE_BITS(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // floor(w * lvl / 2^16)
  function automatic logic signed [17:0] scale(input logic signed [17:0] w, input logic [15:0] l);
    logic signed [34:0] p;
    p = 35'(w) * 35'($signed({1'b0, l}));
    return p[33:16];
  endfunction

  // One envelope tick; leaves time at #1 after the capturing edge
  task automatic tick(input logic g, input int w, input int lvl, input logic act,
                      input int gap = 1, input int hand_w = NOHAND);
    exp_t e;
    logic signed [17:0] ws;
    ws = 18'(w);
    bus.sample_en = 1'b1;
    bus.gate      = g;
    bus.wave_in   = ws;
    e.due  = cyc + 2;
    e.wave = (hand_w == NOHAND) ? scale(ws, mdl_lvl) : 18'(hand_w);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    check("env_level", longint'(bus.env_level), longint'(lvl));
    check("active", longint'(bus.active), longint'(act));
    mdl_lvl = 16'(lvl);
    repeat (gap - 1) @(posedge clk);
    if (gap > 1) #1;
  endtask

  task automatic set_rates(input int a, input int d, input int r, input int s);
    bus.attack_rate  = 16'(a);
    bus.decay_rate   = 16'(d);
    bus.release_rate = 16'(r);
    bus.sustain_lvl  = 16'(s);
  endtask

  // Monitor: every wave_valid pops one expectation and checks value and arrival cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wave_valid) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wave_valid_spurious: got valid with value %0d, expected none (cycle %0d)",
                     bus.wave_out, cyc);
          end else begin
            e = sb_q.pop_front();
            check("wave_due", longint'(cyc), longint'(e.due));
            check("wave_out", longint'(bus.wave_out), longint'(e.wave));
          end
        end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
          e = sb_q.pop_front();
          check("wave_valid_missing", longint'(cyc), longint'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_en = 1'b0;
    bus.gate      = 1'b0;
    bus.wave_in   = 18'sd0;
    set_rates(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_env_level", longint'(bus.env_level), 0);
    check("rst_active", longint'(bus.active), 0);
    check("rst_wave_out", longint'(bus.wave_out), 0);
    check("rst_wave_valid", longint'(bus.wave_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle: gate low, full-scale input, envelope stays silent
    for (int i = 0; i < 3; i++) tick(1'b0, 18'h1FFFF, 0, 1'b0, 4);

    // Attack / decay / sustain, back-to-back ticks
    set_rates(16384, 8192, 10000, 32768);
    tick(1'b1, 1000, 0, 1'b1);
    tick(1'b1, 1000, 16384, 1'b1);
    tick(1'b1, -1000, 32768, 1'b1);
    tick(1'b1, 4096, 49152, 1'b1);
    tick(1'b1, 18'h1FFFF, 65535, 1'b1);
    tick(1'b1, 18'h1FFFF, 57343, 1'b1, 1, 131069);
    tick(1'b1, 77, 49151, 1'b1);
    tick(1'b1, 77, 40959, 1'b1);
    tick(1'b1, 77, 32768, 1'b1);
    tick(1'b1, -131072, 32768, 1'b1, 1, -65536);

    // Release then retrigger from the current level
    tick(1'b0, 5, 32768, 1'b1, 2);
    tick(1'b0, 5, 22768, 1'b1, 2);
    tick(1'b0, 5, 12768, 1'b1, 2);
    tick(1'b1, 5, 12768, 1'b1, 2);
    tick(1'b1, 5, 29152, 1'b1);
    tick(1'b1, 5, 45536, 1'b1);
    tick(1'b1, 5, 61920, 1'b1);
    tick(1'b1, 5, 65535, 1'b1);
    tick(1'b1, 5, 57343, 1'b1);
    tick(1'b1, 5, 49151, 1'b1);
    tick(1'b1, 5, 40959, 1'b1);
    tick(1'b1, 5, 32768, 1'b1);
    tick(1'b1, 5, 32768, 1'b1);

    // Release all the way to idle
    tick(1'b0, -3, 32768, 1'b1);
    tick(1'b0, -3, 22768, 1'b1);
    tick(1'b0, -3, 12768, 1'b1);
    tick(1'b0, -3, 2768, 1'b1);
    tick(1'b0, -3, 0, 1'b0);
    tick(1'b0, -3, 0, 1'b0, 3);

    // Instant attack, instant release
    set_rates(0, 8192, 0, 32768);
    tick(1'b1, 100, 0, 1'b1);
    tick(1'b1, 100, 65535, 1'b1);
    tick(1'b0, 100, 65535, 1'b1);
    tick(1'b0, 100, 0, 1'b0);

    // Gate falls on the tick that would saturate: level holds
    set_rates(40000, 8192, 0, 32768);
    tick(1'b1, -7, 0, 1'b1);
    tick(1'b1, -7, 40000, 1'b1);
    tick(1'b0, -7, 40000, 1'b1);
    tick(1'b1, -7, 40000, 1'b1);
    tick(1'b1, -7, 65535, 1'b1);
    tick(1'b1, -7, 57343, 1'b1);

    // Reset mid-decay with a sample still in the pipeline
    bus.sample_en = 1'b1;
    bus.gate      = 1'b1;
    rst = 1'b1;
    #1;
    bus.sample_en = 1'b0;
    sb_q.delete();
    mdl_lvl = 16'd0;
    check("midrst_env_level", longint'(bus.env_level), 0);
    check("midrst_active", longint'(bus.active), 0);
    check("midrst_wave_out", longint'(bus.wave_out), 0);
    check("midrst_wave_valid", longint'(bus.wave_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Restart from 0, instant decay, then sustain drop jumps
    tick(1'b1, 9, 0, 1'b1);
    tick(1'b1, 9, 40000, 1'b1);
    tick(1'b1, 9, 65535, 1'b1);
    set_rates(40000, 0, 0, 30000);
    tick(1'b1, 9, 30000, 1'b1);
    bus.sustain_lvl = 16'd20000;
    tick(1'b1, 9, 20000, 1'b1);
    tick(1'b0, 9, 20000, 1'b1);
    tick(1'b0, 9, 0, 1'b0);
    check("env_max_const_level", longint'(ENV_MAX) - 65535 + longint'(bus.env_level), 0);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", longint'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
